// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: protocol state codes, byte/counter widths, pointer wrap helper.
package i2c_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [4:0] {
    ST_IDLE          = 5'd0,
    ST_START         = 5'd1,
    ST_DEVICE_ADDR   = 5'd2,
    ST_READ_OR_WRITE = 5'd3,
    ST_ADDR_ACK      = 5'd4,
    ST_REG_ADDR      = 5'd5,
    ST_REG_ACK       = 5'd6,
    ST_WRITE         = 5'd7,
    ST_WRITE_ACK     = 5'd8,
    ST_READ          = 5'd9,
    ST_READ_ACK      = 5'd10,
    ST_STOP          = 5'd11
  } state_e;

  function automatic logic [BYTE_W-1:0] ptr_next(input logic [BYTE_W-1:0] ptr,
                                                 input int num_regs);
    return (ptr == BYTE_W'(num_regs - 1)) ? '0 : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// 2-flop synchronizer plus history flop; rise/fall pulses are valid 2 clk after the pin edge.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic d_sync,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Idle I2C bus is high, so all stages reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign d_sync = sync_q;
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_target_fsm.sv
// I2C register-bank target: address match, pointer write, auto-incrementing burst write/read.
// Bus events act 3 clk after the pin edge; START/STOP/ena override every state.
module i2c_target_fsm
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h2A,
  parameter int         NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [4:0]        state,
  output logic [BYTE_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              busy
);

  localparam logic [BYTE_W:0] NUM_REGS_W = (BYTE_W+1)'(NUM_REGS);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_sync_edge u_scl_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_in   (scl_in),
    .d_sync (scl_s),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_in   (sda_in),
    .d_sync (sda_s),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d;
  logic [BYTE_W-1:0]   ptr_q, ptr_d;
  logic [BYTE_W-1:0]   wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic                match_q, match_d;
  logic                mack_q, mack_d;
  logic                byte_done_q, byte_done_d;
  logic                load_q, load_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;
  logic                we_q, we_d;
  logic                re_q, re_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ptr_q       <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      match_q     <= 1'b0;
      mack_q      <= 1'b0;
      byte_done_q <= 1'b0;
      load_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      match_q     <= match_d;
      mack_q      <= mack_d;
      byte_done_q <= byte_done_d;
      load_q      <= load_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      re_q        <= re_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    match_d     = match_q;
    mack_d      = mack_q;
    byte_done_d = byte_done_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    load_d      = re_q;

    if (!ena) begin
      state_d     = ST_IDLE;
      oe_d        = 1'b0;
      busy_d      = 1'b0;
      cnt_d       = '0;
      byte_done_d = 1'b0;
      load_d      = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      oe_d        = 1'b0;
      busy_d      = 1'b0;
      byte_done_d = 1'b0;
      load_d      = 1'b0;
    end else if (start_det) begin
      state_d     = ST_DEVICE_ADDR;
      cnt_d       = '0;
      oe_d        = 1'b0;
      busy_d      = 1'b1;
      byte_done_d = 1'b0;
      load_d      = 1'b0;
    end else begin
      case (state_q)
        ST_DEVICE_ADDR: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[BYTE_W-2:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d    = sda_s;
              match_d = (shreg_q[6:0] == DEV_ADDR);
              state_d = ST_READ_OR_WRITE;
            end
          end
        end
        // Decision deferred to the falling edge so ACK only appears while SCL is low.
        ST_READ_OR_WRITE: begin
          if (scl_fall) begin
            if (match_q) begin
              oe_d    = 1'b1;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            oe_d        = 1'b0;
            cnt_d       = '0;
            byte_done_d = 1'b0;
            if (rw_q) begin
              re_d    = 1'b1;
              state_d = ST_READ;
            end else begin
              state_d = ST_REG_ADDR;
            end
          end
        end
        ST_REG_ADDR: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[BYTE_W-2:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if ({1'b0, shreg_q} < NUM_REGS_W) begin
              ptr_d   = shreg_q;
              oe_d    = 1'b1;
              state_d = ST_REG_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_REG_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[BYTE_W-2:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              we_d        = 1'b1;
              wdata_d     = {shreg_q[BYTE_W-2:0], sda_s};
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            oe_d        = 1'b1;
            state_d     = ST_WRITE_ACK;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            ptr_d   = ptr_next(ptr_q, NUM_REGS);
            state_d = ST_WRITE;
          end
        end
        // First bit goes out when the bank data lands, a few clk into the SCL low phase.
        ST_READ: begin
          if (load_q) begin
            shreg_d = reg_rdata;
            oe_d    = ~reg_rdata[BYTE_W-1];
          end else if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall) begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              oe_d        = 1'b0;
              state_d     = ST_READ_ACK;
            end else begin
              shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
              oe_d    = ~shreg_q[BYTE_W-2];
            end
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            mack_d = sda_s;
          end else if (scl_fall) begin
            if (!mack_q) begin
              ptr_d   = ptr_next(ptr_q, NUM_REGS);
              re_d    = 1'b1;
              cnt_d   = '0;
              state_d = ST_READ;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    state     = state_q;
    sda_oe    = oe_q;
    busy      = busy_q;
    reg_addr  = ptr_q;
    reg_wdata = wdata_q;
    reg_we    = we_q;
    reg_re    = re_q;
  end

endmodule
